// File: rtl/mem_pkg.sv
// Shared memory-path definitions: size encoding, store FSM states, lane helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package mem_pkg;

    // {Halfword, ByteOrWord} encoding, identical on the load and store paths
    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RDREQ = 2'd1,
        WRITE = 2'd2
    } store_state_t;

    // Halfword dominates, so 2'b11 decodes as a halfword access
    function automatic logic [1:0] size_decode(input logic halfword, input logic byte_or_word);
        logic [1:0] sz;
        if (halfword) begin
            sz = SZ_HALF;
        end else if (byte_or_word) begin
            sz = SZ_BYTE;
        end else begin
            sz = SZ_WORD;
        end
        return sz;
    endfunction

    // Expand a 4-bit lane enable into a 32-bit bit mask
    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        logic [31:0] mask;
        mask = '0;
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/store_lane_gen.sv
// Replicates store data across the 32-bit bus and derives the lane enables.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module store_lane_gen
    import mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] data_o,
    output logic [3:0]  be_o
);

    // Halfwords ignore addr_lo_i[0]: misaligned halfwords land on the aligned pair
    always_comb begin
        data_o = wdata_i;
        be_o   = 4'b1111;
        case (size_i)
            SZ_BYTE: begin
                data_o = {4{wdata_i[7:0]}};
                be_o   = 4'b0001 << addr_lo_i;
            end
            SZ_HALF, 2'b11: begin
                data_o = {2{wdata_i[15:0]}};
                be_o   = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                data_o = wdata_i;
                be_o   = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/store_data_aligner.sv
// Aligns STR/STRB/STRH data onto a word-wide memory port, with optional read-modify-write.
// Latency: direct write 2 cycles accept->ready, RMW 4 cycles (zero-wait memory).
// Backpressure: StoreReady only in IDLE; Mem* outputs held while MemReq && !MemReady.
module store_data_aligner
    import mem_pkg::*;
#(
    parameter bit          USE_BYTE_EN = 1'b1,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              StoreValid,
    output logic              StoreReady,
    input  logic              ByteOrWord,
    input  logic              Halfword,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [31:0]       WriteData,
    output logic              MemReq,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [31:0]       MemWData,
    output logic [3:0]        MemByteEn,
    input  logic              MemReady,
    input  logic [31:0]       MemRData,
    output logic              Busy
);

    store_state_t      state_q, state_d;
    logic [1:0]        size;
    logic [31:0]       lane_data;
    logic [3:0]        lane_be;
    logic              accept;
    logic              direct;
    logic              mem_done;
    logic [31:0]       merged;

    logic [31:0]       data_q, data_d;
    logic [3:0]        be_q, be_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_be_q, mem_be_d;

    store_lane_gen u_lane_gen (
        .size_i    (size),
        .addr_lo_i (Addr[1:0]),
        .wdata_i   (WriteData),
        .data_o    (lane_data),
        .be_o      (lane_be)
    );

    // Decode the request and the completion/merge terms shared by the FSM processes
    always_comb begin
        size     = size_decode(Halfword, ByteOrWord);
        accept   = StoreValid && (state_q == IDLE);
        direct   = USE_BYTE_EN || (size == SZ_WORD);
        mem_done = mem_req_q && MemReady;
        merged   = (MemRData & ~be_to_mask(be_q)) | (data_q & be_to_mask(be_q));
    end

    // State register; reset aborts any in-flight access immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: word or byte-enabled stores write directly, others read first
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = direct ? WRITE : RDREQ;
                end
            end
            RDREQ: begin
                if (mem_done) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (mem_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath next values; the RMW write is issued one cycle after the
    // read completes, giving the memory a read-to-write turnaround cycle
    always_comb begin
        StoreReady  = (state_q == IDLE);
        Busy        = (state_q != IDLE);
        data_d      = data_q;
        be_d        = be_q;
        mem_req_d   = mem_req_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d      = lane_data;
                    be_d        = lane_be;
                    mem_addr_d  = {Addr[ADDR_W-1:2], 2'b00};
                    mem_req_d   = 1'b1;
                    mem_wdata_d = lane_data;
                    if (direct) begin
                        mem_write_d = 1'b1;
                        mem_be_d    = USE_BYTE_EN ? lane_be : 4'b1111;
                    end else begin
                        mem_write_d = 1'b0;
                        mem_be_d    = 4'b1111;
                    end
                end
            end
            RDREQ: begin
                if (mem_done) begin
                    mem_req_d   = 1'b0;
                    mem_write_d = 1'b1;
                    mem_wdata_d = merged;
                    mem_be_d    = 4'b1111;
                end
            end
            WRITE: begin
                if (!mem_req_q) begin
                    mem_req_d = 1'b1;
                end else if (MemReady) begin
                    mem_req_d   = 1'b0;
                    mem_write_d = 1'b0;
                end
            end
            default: begin
                mem_req_d   = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    // Capture and memory-port registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q      <= '0;
            be_q        <= '0;
            mem_req_q   <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else begin
            data_q      <= data_d;
            be_q        <= be_d;
            mem_req_q   <= mem_req_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
        end
    end

    assign MemReq    = mem_req_q;
    assign MemWrite  = mem_write_q;
    assign MemAddr   = mem_addr_q;
    assign MemWData  = mem_wdata_q;
    assign MemByteEn = mem_be_q;

endmodule

// File: doc/store_data_aligner.md
Name: store_data_aligner

Overview:
- Write-direction counterpart of the load-side byte/halfword extractor, for STR, STRB and STRH.
- Accepts one store per handshake from the memory stage and replicates the byte or halfword across the 32-bit bus.
- Generates byte enables and issues a single word-aligned write to data memory.
- For memories without byte enables (USE_BYTE_EN=0), performs read-modify-write: read the word, merge the lanes, write back.

Parameters:
- USE_BYTE_EN, 1: 1 = memory honours MemByteEn, so sub-word stores are a single write; 0 = sub-word stores use read-modify-write and MemByteEn is driven 4'b1111.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- StoreValid  in  1  store request valid.
- StoreReady  out  1  block can accept a request.
- ByteOrWord  in  1  with Halfword selects size; same encoding as the load path.
- Halfword  in  1  {Halfword,ByteOrWord}: 00 word, 01 byte, 1x halfword.
- Addr  in  ADDR_W  byte address.
- WriteData  in  32  register data; only the LSBs are used for sub-word stores.
- MemReq  out  1  memory request valid.
- MemWrite  out  1  1 = write, 0 = read; valid with MemReq.
- MemAddr  out  ADDR_W  word-aligned address, bits [1:0] = 0.
- MemWData  out  32  write data.
- MemByteEn  out  4  lane enables; bit i covers [8i+7:8i].
- MemReady  in  1  memory accepts the request; read data valid in the same cycle.
- MemRData  in  32  read data for RMW.
- Busy  out  1  store in flight (state != IDLE).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; StoreReady=1 once reset releases.
  - MemReq=0, MemWrite=0, MemAddr=0, MemWData=0, MemByteEn=0, Busy=0.
  - Internal capture registers cleared.
- Lane rules, computed at capture:
  - Word: data=WriteData; BE=1111; Addr[1:0] ignored.
  - Byte: data={4{WriteData[7:0]}}; BE=0001<<Addr[1:0].
  - Halfword: data={2{WriteData[15:0]}}; BE=Addr[1]?1100:0011; Addr[0] ignored (no misaligned support).
- Handshake:
  - Accept when StoreValid & StoreReady at the rising edge; capture aligned data, BE and word address.
  - StoreReady=1 only in IDLE; one store outstanding at a time.
  - MemReq and all Mem* outputs are registered and held stable while MemReq=1 and MemReady=0.
  - A request completes on the edge where MemReq & MemReady.
- FSM (IDLE, WRITE, RDREQ):
  - IDLE: on accept -> WRITE if USE_BYTE_EN=1 or the store is a word; else -> RDREQ.
  - RDREQ: MemReq=1, MemWrite=0, MemByteEn=1111. On MemReady, merged = (MemRData & ~mask) | (data & mask), mask = byte-expanded BE. Load merged into MemWData -> WRITE.
  - WRITE: MemReq=1, MemWrite=1. MemByteEn = captured BE if USE_BYTE_EN=1, else 1111. On MemReady -> IDLE.
- Latency, with zero-wait memory (MemReady high the cycle MemReq rises):
  - Direct write: MemReq first asserted the cycle after accept; StoreReady returns 2 cycles after accept.
  - RMW: 4 cycles from accept to StoreReady.
- Boundaries:
  - StoreValid while Busy: ignored. The requester must hold the request, since StoreReady=0.
  - MemReady while MemReq=0: ignored.
  - Wait states of any length: outputs held.
  - Back-to-back stores: earliest next accept is the cycle StoreReady rises; no bubble-free issue.
  - Reset mid-RMW or mid-write: abort immediately; MemReq drops asynchronously; no partial write re-issued.
  - Halfword with Addr[0]=1: treated as Addr[0]=0, no fault.
  - {Halfword,ByteOrWord}=11: halfword.

Decomposition:
- Shared package (mem_pkg):
  - Size encoding constants SZ_WORD=2'b00, SZ_BYTE=2'b01, SZ_HALF=2'b10, shared with the load-side selector.
  - State enum store_state_t {IDLE, RDREQ, WRITE}.
- One combinational sub-module, store_lane_gen: (size, Addr[1:0], WriteData) -> (replicated data, BE). The FSM, capture registers and merge stay in store_data_aligner.

Test Plan:
- Word store, USE_BYTE_EN=1: Addr=0x1003, WriteData=0xDEADBEEF, MemReady tied 1 -> one write, MemAddr=0x1000, MemWData=0xDEADBEEF, BE=1111; StoreReady back 2 cycles after accept.
- Byte store sweep, USE_BYTE_EN=1: WriteData=0x123456AB, Addr[1:0]=0..3 -> MemWData=0xABABABAB; BE=0001, 0010, 0100, 1000.
- Halfword store: WriteData=0xFFFFCAFE, Addr=0x2002 -> MemWData=0xCAFECAFE, BE=1100; Addr=0x2001 -> BE=0011.
- RMW byte, USE_BYTE_EN=0: Addr=0x3002, WriteData=0x5A, MemRData=0x11223344 -> read then write; MemWData=0x115A3344, BE=1111; 4 cycles to StoreReady.
- Wait states: MemReady low 3 cycles in WRITE, with StoreValid pulsed during Busy -> Mem* outputs stable throughout; second request accepted only after return to IDLE.
- Reset asserted in RDREQ -> MemReq=0 within the same cycle; no write issued after reset release; StoreReady=1.
